axil2sreg_bridge: RTL and testbench
===================================

// Module: axil2sreg_bridge
// PURPOSE
//  AXI4-Lite slave to simple-register-bus (SREG) initiator. PS writes/reads over AXI-Lite become single-cycle
//  en/wen/addr/din strobes to SREG targets (e.g. AXI2S control/status bank); combinational target dout is sampled.
//  Sits between the PS GP port interconnect and all SREG register banks; one transaction in flight at a time.
// PARAMETERS
//  ADDR_W   18   SREG byte-address width; s_axi_*addr[ADDR_W-1:0] used, upper bits ignored
//  DATA_W   32   data width (fixed 32; WSTRB is 4 bits)
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset, asynchronous, active-high
//  s_awaddr/valid/ready  in/in/out  32/1/1   AXI-Lite write address channel
//  s_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1   write data channel
//  s_bresp/bvalid/bready  out/out/in  2/1/1   write response channel
//  s_araddr/arvalid/arready  in/in/out  32/1/1   read address channel
//  s_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1   read data channel
//  sreg_en        out  1       SREG access strobe (one cycle per access)
//  sreg_wen       out  1       1=write, 0=read; meaningful only with sreg_en
//  sreg_addr      out  ADDR_W  SREG byte address
//  sreg_din       out  32      write data to targets
//  sreg_dout      in   32      combinational read data from targets (OR of all banks), valid same cycle as en
// BEHAVIOUR
//  Reset: all *ready/*valid=0, sreg_en=sreg_wen=0, sreg_addr=0, sreg_din=0, s_rdata=0, resp=0, FSM=IDLE,
//   AW/W holding regs empty, last_rd=0. Reset mid-transaction aborts it; no response issued.
//  States: IDLE, WR_RMW (read for merge), WR_EXEC, WR_RESP, RD_EXEC, RD_RESP.
//  IDLE: awready=!aw_held, wready=!w_held, arready=!(aw_held|w_held); AW and W latched independently, any order.
//   Decision when write complete (aw_held&w_held, incl. same-cycle latches) and/or AR handshake pending:
//   both ready -> serve the class not served last (last_rd flag), other waits; only one -> serve it.
//   arready is deasserted in the decision cycle if the write is selected.
//  Misaligned (addr[1:0]!=0): no SREG cycle; go straight to *_RESP with resp=SLVERR(2'b10), rdata=0.
//  Write, wstrb=4'hF: IDLE->WR_EXEC (en=1,wen=1,addr,din=wdata for 1 cycle)->WR_RESP. bvalid 2 cycles after
//   the later of AW/W handshake.
//  Write, wstrb partial (incl. 0): IDLE->WR_RMW (en=1,wen=0; capture dout)->WR_EXEC (din = byte-merge:
//   strb?wdata:dout per byte)->WR_RESP; bvalid 3 cycles after handshake. wstrb=0 still writes back dout.
//  Read: IDLE->RD_EXEC (en=1,wen=0; s_rdata<=sreg_dout at end of cycle)->RD_RESP; rvalid 2 cycles after AR.
//  *_RESP: valid held with stable data/resp until ready; on handshake -> IDLE, holding regs cleared.
//   bresp/rresp=OKAY for aligned accesses. No unmapped-address decode: reads of holes return dout as driven.
//  sreg_en high exactly one cycle per SREG access, never in IDLE/*_RESP; sreg_addr/din hold last value.
//  Backpressure: bready/rready low indefinitely stalls the bridge; no timeout.
// STRUCTURE
//  Shared package/include: AXI resp codes (RESP_OKAY, RESP_SLVERR), FSM state encoding localparams.
//  Single module; byte-merge is a small function, no sub-module warranted.
// TESTING
//  1 Write 0x0000_0007 to 0x00, wstrb=F, AW/W same cycle -> one en&wen pulse addr=0x00 din=7; bvalid at +2, OKAY.
//  2 Target dout=0xAABBCCDD at 0x10; write wdata=0x11223344 wstrb=4'b0101 -> read pulse, then write
//    din=0xAA22CC44; bvalid at +3.
//  3 Read 0x14 with dout=0x12345678, rready low 5 cycles -> rvalid held, rdata stable 0x12345678; en pulses once.
//  4 AW and AR valid same cycle after a read -> write served first, then read; next tie -> read first.
//  5 W before AW by 3 cycles; then araddr=0x02 -> write completes normally; read returns SLVERR, no en pulse.
//  6 Assert rst during WR_RMW -> all outputs to reset values immediately, no bvalid; next write proceeds normally.

Source files
------------

// File: rtl/axil2sreg_bridge_pkg.sv
// ---------------------------------------------------------------------------
// axil2sreg_bridge_pkg
//   Shared definitions for the AXI4-Lite to SREG bridge: AXI response codes,
//   the bridge FSM state encoding and the byte-lane merge used when a write
//   with a partial strobe is folded into the target's current contents.
// ---------------------------------------------------------------------------
package axil2sreg_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] STRB_ALL    = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_RMW  = 3'd1,
    WR_EXEC = 3'd2,
    WR_RESP = 3'd3,
    RD_EXEC = 3'd4,
    RD_RESP = 3'd5
  } state_t;

  // Per byte lane: take the new AXI byte where the strobe is set, otherwise
  // keep the byte that the target currently holds.
  function automatic logic [31:0] byte_merge(input logic [31:0] new_data,
                                             input logic [31:0] old_data,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_data;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil2sreg_bridge.sv
// ---------------------------------------------------------------------------
// axil2sreg_bridge
//   AXI4-Lite slave that turns PS register accesses into single-cycle strobes
//   on the simple register bus (SREG). One transaction is in flight at a time.
//   Partial-strobe writes are done as read-modify-write; misaligned accesses
//   are answered with SLVERR without touching the SREG bus.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   s_aw*, s_w*, s_b*              AXI-Lite write address / data / response
//   s_ar*, s_r*                    AXI-Lite read address / data
//   sreg_en                        one-cycle access strobe
//   sreg_wen                       1 = write, 0 = read (qualified by sreg_en)
//   sreg_addr, sreg_din            byte address and write data (held between accesses)
//   sreg_dout                      combinational read data from the targets
// ---------------------------------------------------------------------------
module axil2sreg_bridge
  import axil2sreg_bridge_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [31:0]       s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              sreg_en,
  output logic              sreg_wen,
  output logic [ADDR_W-1:0] sreg_addr,
  output logic [DATA_W-1:0] sreg_din,
  input  logic [DATA_W-1:0] sreg_dout
);

  state_t state, next_state;

  logic              aw_held, w_held, last_rd;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [3:0]        w_strb_q;

  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        wr_strb;
  logic              wr_misaligned, rd_misaligned;
  logic              rd_req, wr_go, rd_go;
  logic              awready_c, wready_c, arready_c;

  // Only the low ADDR_W address bits reach the SREG bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_awaddr[31:ADDR_W], s_araddr[31:ADDR_W]};

  // The write can be decided in the same cycle its last channel handshakes,
  // so look through the holding registers to the live channel when empty.
  assign wr_addr       = aw_held ? aw_addr_q : s_awaddr[ADDR_W-1:0];
  assign wr_data       = w_held  ? w_data_q  : s_wdata;
  assign wr_strb       = w_held  ? w_strb_q  : s_wstrb;
  assign wr_misaligned = (wr_addr[1:0] != 2'b00);
  assign rd_misaligned = (s_araddr[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state, channel readies and the read/write arbitration. A complete
  // write and a pending read compete round-robin via last_rd; AR is only
  // accepted while no write half is parked, and is refused in the cycle the
  // write wins.
  always_comb begin
    next_state = state;
    awready_c  = 1'b0;
    wready_c   = 1'b0;
    arready_c  = 1'b0;
    rd_req     = 1'b0;
    wr_go      = 1'b0;
    rd_go      = 1'b0;
    case (state)
      IDLE: begin
        awready_c = !aw_held;
        wready_c  = !w_held;
        rd_req    = s_arvalid && !(aw_held || w_held);
        wr_go     = (aw_held || s_awvalid) && (w_held || s_wvalid) && (!rd_req || last_rd);
        rd_go     = rd_req && !wr_go;
        arready_c = !(aw_held || w_held) && !wr_go;
        if (wr_go) begin
          if (wr_misaligned)            next_state = WR_RESP;
          else if (wr_strb == STRB_ALL) next_state = WR_EXEC;
          else                          next_state = WR_RMW;
        end else if (rd_go) begin
          next_state = rd_misaligned ? RD_RESP : RD_EXEC;
        end
      end
      WR_RMW:  next_state = WR_EXEC;
      WR_EXEC: next_state = WR_RESP;
      WR_RESP: if (s_bready) next_state = IDLE;
      RD_EXEC: next_state = RD_RESP;
      RD_RESP: if (s_rready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Readies are forced low while reset is asserted so nothing is accepted.
  assign s_awready = awready_c && !rst;
  assign s_wready  = wready_c  && !rst;
  assign s_arready = arready_c && !rst;

  assign sreg_en  = (state == WR_RMW) || (state == WR_EXEC) || (state == RD_EXEC);
  assign sreg_wen = (state == WR_EXEC);
  assign s_bvalid = (state == WR_RESP);
  assign s_rvalid = (state == RD_RESP);

  // Holding registers, SREG address/data, captured read data and responses.
  // sreg_din for a partial write is built during WR_RMW from the target's
  // current value; a full-strobe write loads it at the decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      last_rd   <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      sreg_addr <= '0;
      sreg_din  <= '0;
      s_rdata   <= '0;
      s_bresp   <= RESP_OKAY;
      s_rresp   <= RESP_OKAY;
    end else begin
      if (s_awvalid && awready_c) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_awaddr[ADDR_W-1:0];
      end
      if (s_wvalid && wready_c) begin
        w_held   <= 1'b1;
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end
      case (state)
        IDLE: begin
          if (wr_go) begin
            last_rd <= 1'b0;
            s_bresp <= wr_misaligned ? RESP_SLVERR : RESP_OKAY;
            if (!wr_misaligned) begin
              sreg_addr <= wr_addr;
              if (wr_strb == STRB_ALL) sreg_din <= wr_data;
            end
          end else if (rd_go) begin
            last_rd <= 1'b1;
            if (rd_misaligned) begin
              s_rresp <= RESP_SLVERR;
              s_rdata <= '0;
            end else begin
              s_rresp   <= RESP_OKAY;
              sreg_addr <= s_araddr[ADDR_W-1:0];
            end
          end
        end
        WR_RMW:  sreg_din <= byte_merge(w_data_q, sreg_dout, w_strb_q);
        RD_EXEC: s_rdata  <= sreg_dout;
        WR_RESP: begin
          if (s_bready) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil2sreg_bridge.sv
// ---------------------------------------------------------------------------
// tb_axil2sreg_bridge
//   Bench for the AXI-Lite to SREG bridge. A word-addressed memory plays the
//   SREG target and logs every strobe; a reference memory tracks what the
//   targets should hold from AXI-level rules.
// ---------------------------------------------------------------------------
module tb_axil2sreg_bridge;

  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [31:0]       s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;
  logic              sreg_en;
  logic              sreg_wen;
  logic [ADDR_W-1:0] sreg_addr;
  logic [31:0]       sreg_din;
  logic [31:0]       sreg_dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axil2sreg_bridge #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .sreg_en   (sreg_en),
    .sreg_wen  (sreg_wen),
    .sreg_addr (sreg_addr),
    .sreg_din  (sreg_din),
    .sreg_dout (sreg_dout)
  );

  // SREG target: 256 words addressed by addr[9:2], combinational read.
  typedef struct {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;
  } acc_t;

  acc_t        acc_log[$];
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  assign sreg_dout = mem[sreg_addr[9:2]];

  // Target write port and strobe log; the bench preloads words via poke_*.
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    if (sreg_en) begin
      acc_log.push_back('{wen: sreg_wen, addr: sreg_addr, din: sreg_din});
      if (sreg_wen) mem[sreg_addr[9:2]] <= sreg_din;
    end
  end

  // Hard stop in case a wait is never bounded properly.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Expected target contents after a strobed write: bytes with strobe set
  // come from the AXI data, the rest keep their old value.
  function automatic logic [31:0] ref_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] strb);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
    return (new_v & mask) | (old_v & ~mask);
  endfunction

  task automatic poke(input logic [7:0] idx, input logic [31:0] v);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = v;
    ref_mem[idx] = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // One AXI write; AW and W start after their own lead (in cycles). lat is the
  // number of cycles from the later handshake to bvalid.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lead, input int w_lead,
                           output int lat, output logic [1:0] resp, output bit to);
    int cyc;
    bit aw_done, w_done;
    cyc = 0; aw_done = 0; w_done = 0; lat = -1; resp = 2'bxx; to = 0;
    s_bready = 1'b1;
    @(negedge clk);
    while (!(aw_done && w_done) && cyc < 60) begin
      if (!aw_done && cyc >= aw_lead) begin s_awvalid = 1'b1; s_awaddr = addr; end
      if (!w_done && cyc >= w_lead) begin s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb; end
      #1;
      if (s_awvalid && s_awready) aw_done = 1;
      if (s_wvalid && s_wready) w_done = 1;
      @(negedge clk);
      if (aw_done) s_awvalid = 1'b0;
      if (w_done) s_wvalid = 1'b0;
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      s_awvalid = 1'b0; s_wvalid = 1'b0; to = 1;
      return;
    end
    lat = 1;
    while (!s_bvalid && lat < 60) begin @(negedge clk); lat++; end
    if (!s_bvalid) begin to = 1; return; end
    resp = s_bresp;
    @(posedge clk);
  endtask

  // One AXI read with rready held high; lat counts cycles from AR handshake to rvalid.
  task automatic axi_read(input logic [31:0] addr, input int ar_lead,
                          output int lat, output logic [31:0] data, output logic [1:0] resp, output bit to);
    int cyc;
    bit done;
    cyc = 0; done = 0; lat = -1; data = 'x; resp = 2'bxx; to = 0;
    s_rready = 1'b1;
    @(negedge clk);
    while (!done && cyc < 60) begin
      if (cyc >= ar_lead) begin s_arvalid = 1'b1; s_araddr = addr; end
      #1;
      if (s_arvalid && s_arready) done = 1;
      @(negedge clk);
      if (done) s_arvalid = 1'b0;
      cyc++;
    end
    if (!done) begin s_arvalid = 1'b0; to = 1; return; end
    lat = 1;
    while (!s_rvalid && lat < 60) begin @(negedge clk); lat++; end
    if (!s_rvalid) begin to = 1; return; end
    data = s_rdata;
    resp = s_rresp;
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 1'b1; s_araddr = '0; s_arvalid = 0; s_rready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      poke(8'(i), v);
    end
    @(negedge clk);
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, sreg_en, sreg_wen} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, sreg_en, sreg_wen});
    end
    checks++;
    if ({sreg_addr, sreg_din, s_rdata, s_bresp, s_rresp} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: addr=%h din=%h rdata=%h bresp=%b rresp=%b expected all 0",
               sreg_addr, sreg_din, s_rdata, s_bresp, s_rresp);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL idle_ready: got %b expected 111", {s_awready, s_wready, s_arready});
    end
  endtask

  task automatic test_full_write();
    int lat; logic [1:0] resp; bit to;
    acc_log.delete();
    axi_write(32'h0, 32'h7, 4'hF, 0, 0, lat, resp, to);
    ref_mem[0] = 32'h7;
    checks++;
    if (to || lat != 2 || resp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL full_write_resp: to=%0d lat=%0d resp=%b expected lat=2 resp=00", to, lat, resp);
    end
    checks++;
    if (acc_log.size() != 1 || acc_log[0].wen !== 1'b1 || acc_log[0].addr !== 18'h0 || acc_log[0].din !== 32'h7) begin
      errors++;
      $display("[TB] FAIL full_write_strobe: n=%0d expected one write addr=0 din=7", acc_log.size());
    end
  endtask

  task automatic test_partial_write();
    int lat; logic [1:0] resp; bit to;
    poke(8'd4, 32'hAABBCCDD);
    acc_log.delete();
    axi_write(32'h10, 32'h11223344, 4'b0101, 0, 0, lat, resp, to);
    ref_mem[4] = ref_merge(ref_mem[4], 32'h11223344, 4'b0101);
    checks++;
    if (to || lat != 3 || resp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rmw_resp: to=%0d lat=%0d resp=%b expected lat=3 resp=00", to, lat, resp);
    end
    checks++;
    if (acc_log.size() != 2) begin
      errors++;
      $display("[TB] FAIL rmw_count: got %0d strobes expected 2", acc_log.size());
    end else begin
      checks++;
      if (acc_log[0].wen !== 1'b0 || acc_log[0].addr !== 18'h10 || acc_log[1].wen !== 1'b1 ||
          acc_log[1].addr !== 18'h10 || acc_log[1].din !== 32'hAA22CC44) begin
        errors++;
        $display("[TB] FAIL rmw_seq: wen0=%b wen1=%b din=%h expected read then write din=aa22cc44",
                 acc_log[0].wen, acc_log[1].wen, acc_log[1].din);
      end
    end
  endtask

  task automatic test_read_backpressure();
    poke(8'd5, 32'h12345678);
    acc_log.delete();
    @(negedge clk);
    s_rready = 1'b0; s_arvalid = 1'b1; s_araddr = 32'h14;
    #1;
    checks++;
    if (s_arready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rd_arready: got %b expected 1", s_arready);
    end
    @(negedge clk);
    s_arvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== 32'h12345678 || s_rresp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rd_first: rvalid=%b rdata=%h rresp=%b expected 1 12345678 00", s_rvalid, s_rdata, s_rresp);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin poke_en = 1'b1; poke_idx = 8'd5; poke_val = 32'hDEADBEEF; end
      else poke_en = 1'b0;
      @(negedge clk);
      checks++;
      if (s_rvalid !== 1'b1 || s_rdata !== 32'h12345678) begin
        errors++;
        $display("[TB] FAIL rd_stall_hold: cycle %0d rvalid=%b rdata=%h expected 1 12345678", i, s_rvalid, s_rdata);
      end
    end
    poke_en = 1'b0;
    ref_mem[5] = 32'hDEADBEEF;
    s_rready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (s_rvalid !== 1'b0 || acc_log.size() != 1) begin
      errors++;
      $display("[TB] FAIL rd_done: rvalid=%b strobes=%0d expected 0 and 1", s_rvalid, acc_log.size());
    end
  endtask

  task automatic test_arbitration();
    int wl, rl; logic [1:0] wr_resp, rd_resp; logic [31:0] rd_data; bit wto, rto;
    axi_read(32'h40, 0, rl, rd_data, rd_resp, rto);
    acc_log.delete();
    fork
      axi_write(32'h20, 32'h0BAD_F00D, 4'hF, 0, 0, wl, wr_resp, wto);
      axi_read(32'h24, 0, rl, rd_data, rd_resp, rto);
    join
    ref_mem[8] = 32'h0BAD_F00D;
    checks++;
    if (wto || rto || acc_log.size() != 2) begin
      errors++;
      $display("[TB] FAIL tie1_count: wto=%0d rto=%0d strobes=%0d expected 0 0 2", wto, rto, acc_log.size());
    end else begin
      checks++;
      if (acc_log[0].wen !== 1'b1 || acc_log[1].wen !== 1'b0 || wl != 2 || rd_data !== ref_mem[9]) begin
        errors++;
        $display("[TB] FAIL tie1_order: first_wen=%b wlat=%0d rdata=%h expected write first, lat 2, rdata %h",
                 acc_log[0].wen, wl, rd_data, ref_mem[9]);
      end
    end
    axi_write(32'h28, 32'h5A5A_0001, 4'hF, 0, 0, wl, wr_resp, wto);
    ref_mem[10] = 32'h5A5A_0001;
    acc_log.delete();
    fork
      axi_write(32'h2C, 32'h1357_9BDF, 4'hF, 0, 0, wl, wr_resp, wto);
      axi_read(32'h20, 0, rl, rd_data, rd_resp, rto);
    join
    ref_mem[11] = 32'h1357_9BDF;
    checks++;
    if (wto || rto || acc_log.size() != 2) begin
      errors++;
      $display("[TB] FAIL tie2_count: wto=%0d rto=%0d strobes=%0d expected 0 0 2", wto, rto, acc_log.size());
    end else begin
      checks++;
      if (acc_log[0].wen !== 1'b0 || acc_log[1].wen !== 1'b1 || rl != 2 || rd_data !== 32'h0BAD_F00D) begin
        errors++;
        $display("[TB] FAIL tie2_order: first_wen=%b rlat=%0d rdata=%h expected read first, lat 2, rdata 0badf00d",
                 acc_log[0].wen, rl, rd_data);
      end
    end
  endtask

  task automatic test_w_before_aw_misaligned();
    int lat; logic [1:0] resp; logic [31:0] data; bit to;
    acc_log.delete();
    axi_write(32'h34, 32'hFACE_0042, 4'hF, 3, 0, lat, resp, to);
    ref_mem[13] = 32'hFACE_0042;
    checks++;
    if (to || lat != 2 || resp !== 2'b00 || acc_log.size() != 1) begin
      errors++;
      $display("[TB] FAIL w_first: to=%0d lat=%0d resp=%b strobes=%0d expected lat=2 resp=00 strobes=1",
               to, lat, resp, acc_log.size());
    end
    acc_log.delete();
    axi_read(32'h02, 0, lat, data, resp, to);
    checks++;
    if (to || lat != 1 || resp !== 2'b10 || data !== 32'h0 || acc_log.size() != 0) begin
      errors++;
      $display("[TB] FAIL misaligned_read: to=%0d lat=%0d resp=%b rdata=%h strobes=%0d expected 1 10 0 0",
               to, lat, resp, data, acc_log.size());
    end
  endtask

  task automatic test_reset_mid_rmw();
    int lat; logic [1:0] resp; bit to, saw_b;
    acc_log.delete();
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = 32'h30; s_wvalid = 1'b1; s_wdata = 32'h5566_7788; s_wstrb = 4'b0011;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    checks++;
    if (sreg_en !== 1'b1 || sreg_wen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rmw_phase: en=%b wen=%b expected 1 0", sreg_en, sreg_wen);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({sreg_en, sreg_wen, s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 7'b0 ||
        sreg_addr !== '0 || sreg_din !== '0) begin
      errors++;
      $display("[TB] FAIL abort_reset: ctrl=%b addr=%h din=%h expected all 0",
               {sreg_en, sreg_wen, s_bvalid, s_rvalid, s_awready, s_wready, s_arready}, sreg_addr, sreg_din);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_b = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_bvalid) saw_b = 1;
    end
    checks++;
    if (saw_b || acc_log.size() != 0 || mem[12] !== ref_mem[12]) begin
      errors++;
      $display("[TB] FAIL abort_effect: bvalid_seen=%0d strobes=%0d mem=%h expected 0 0 %h",
               saw_b, acc_log.size(), mem[12], ref_mem[12]);
    end
    axi_write(32'h30, 32'hCAFE_F00D, 4'hF, 0, 0, lat, resp, to);
    ref_mem[12] = 32'hCAFE_F00D;
    checks++;
    if (to || lat != 2 || resp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL after_abort_write: to=%0d lat=%0d resp=%b expected lat=2 resp=00", to, lat, resp);
    end
  endtask

  task automatic test_random();
    int lat, exp_lat, exp_n, bad;
    logic [1:0] resp, exp_resp;
    logic [31:0] r, addr, data, rdata, exp_data;
    logic [7:0] idx;
    logic [1:0] low;
    logic [3:0] strb;
    bit to, is_wr;
    for (int t = 0; t < 40; t++) begin
      r     = $urandom;
      idx   = 8'($urandom_range(0, 255));
      low   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      addr  = {r[31:18], 8'h00, idx, low};
      is_wr = ($urandom_range(0, 1) == 1);
      acc_log.delete();
      if (is_wr) begin
        data = $urandom;
        strb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
        axi_write(addr, data, strb, $urandom_range(0, 2), $urandom_range(0, 2), lat, resp, to);
        if (low != 2'b00) begin
          exp_lat = 1; exp_resp = 2'b10; exp_n = 0;
        end else begin
          exp_resp = 2'b00;
          exp_lat  = (strb == 4'hF) ? 2 : 3;
          exp_n    = (strb == 4'hF) ? 1 : 2;
          ref_mem[idx] = ref_merge(ref_mem[idx], data, strb);
        end
        checks++;
        if (to || lat != exp_lat || resp !== exp_resp || acc_log.size() != exp_n) begin
          errors++;
          $display("[TB] FAIL rand_write[%0d]: to=%0d lat=%0d resp=%b strobes=%0d expected %0d %b %0d",
                   t, to, lat, resp, acc_log.size(), exp_lat, exp_resp, exp_n);
        end else if (exp_n > 0) begin
          checks++;
          if (acc_log[exp_n-1].wen !== 1'b1 || acc_log[exp_n-1].addr !== addr[17:0] ||
              acc_log[exp_n-1].din !== ref_mem[idx]) begin
            errors++;
            $display("[TB] FAIL rand_write_data[%0d]: addr=%h din=%h expected addr=%h din=%h",
                     t, acc_log[exp_n-1].addr, acc_log[exp_n-1].din, addr[17:0], ref_mem[idx]);
          end
        end
      end else begin
        axi_read(addr, $urandom_range(0, 2), lat, rdata, resp, to);
        exp_lat  = (low != 2'b00) ? 1 : 2;
        exp_resp = (low != 2'b00) ? 2'b10 : 2'b00;
        exp_data = (low != 2'b00) ? 32'h0 : ref_mem[idx];
        exp_n    = (low != 2'b00) ? 0 : 1;
        checks++;
        if (to || lat != exp_lat || resp !== exp_resp || rdata !== exp_data || acc_log.size() != exp_n) begin
          errors++;
          $display("[TB] FAIL rand_read[%0d]: to=%0d lat=%0d resp=%b rdata=%h strobes=%0d expected %0d %b %h %0d",
                   t, to, lat, resp, rdata, acc_log.size(), exp_lat, exp_resp, exp_data, exp_n);
        end
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL final_mem: %0d words differ, expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_partial_write();
    test_read_backpressure();
    test_arbitration();
    test_w_before_aw_misaligned();
    test_reset_mid_rmw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
